// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a loaded value to zero, flags zero, pulses expired.
// Latency: load/decrement visible on count one clock after the sampling edge.
// Optional prescaler enabled by macro DOWN_COUNTER_PRESCALE_EN (parameter PRESCALE).
module down_counter_timer #(
  parameter int WIDTH = 5
`ifdef DOWN_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expired,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             expired_n;
  logic             step;

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic          pre_active;

  assign pre_active = enable && ((state == ARMED) || (state == RUN));
  assign step       = pre_active && (pre_cnt == PRE_LAST);

  // Prescaler: counts enabled active cycles, wraps on each decrement tick, cleared by load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
    end else if (pre_active) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end
  end
`else
  // Without a prescaler every enabled cycle is a decrement opportunity.
  assign step = 1'b1;
`endif

  // Next-state, next-count and pulse decode; priority is load > enable > hold.
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload_reg;
    expired_n = 1'b0;
    if (load) begin
      count_n  = data;
      reload_n = data;
      state_n  = (data != '0) ? ARMED : IDLE;
    end else if (enable && (count != '0)) begin
      // Enabled with a nonzero count: running even on cycles the prescaler skips.
      state_n = RUN;
      if (step) begin
        if (count == ONE) begin
          expired_n = 1'b1;
          if (auto_reload) begin
            count_n = reload_reg;
          end else begin
            count_n = '0;
            state_n = DONE;
          end
        end else begin
          count_n = count - ONE;
        end
      end
    end else if (!enable && (state == RUN)) begin
      state_n = (count == '0) ? DONE : ARMED;
    end
  end

  // State, count and flags; zero/busy come from next-state so they track count on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      zero       <= 1'b1;
      expired    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      zero       <= (count_n == '0);
      expired    <= expired_n;
      busy       <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer (default build, no prescaler).
// Table of per-cycle vectors plus hand-written asynchronous reset sequences.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] data;
  logic       load, enable, auto_reload;
  logic [4:0] count;
  logic       zero, expired, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       ld;
    logic       en;
    logic       ar;
    logic [4:0] d;
    logic [4:0] c;
    logic       z;
    logic       x;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  down_counter_timer #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .enable(enable),
    .auto_reload(auto_reload), .count(count), .zero(zero),
    .expired(expired), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int idx, input logic [4:0] c,
                           input logic z, input logic x, input logic b);
    check({nm, ".count"},   idx, 32'(count),   32'(c));
    check({nm, ".zero"},    idx, 32'(zero),    32'(z));
    check({nm, ".expired"}, idx, 32'(expired), 32'(x));
    check({nm, ".busy"},    idx, 32'(busy),    32'(b));
  endtask

  task automatic add(input string nm, input logic ld, input logic en, input logic ar,
                     input logic [4:0] d, input logic [4:0] c, input logic z,
                     input logic x, input logic b);
    vec_t v;
    v.name = nm; v.ld = ld; v.en = en; v.ar = ar; v.d = d;
    v.c = c; v.z = z; v.x = x; v.b = b;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic en, input logic ar, input logic [4:0] d);
    @(negedge clk);
    load = ld; enable = en; auto_reload = ar; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; data = '0; load = 1'b0; enable = 1'b0; auto_reload = 1'b0;

    // Load 21, count down five cycles, then pause.
    add("dn21", 1, 0, 0, 5'd21, 5'd21, 0, 0, 0);
    add("dn21", 0, 1, 0, 5'd0,  5'd20, 0, 0, 1);
    add("dn21", 0, 1, 0, 5'd0,  5'd19, 0, 0, 1);
    add("dn21", 0, 1, 0, 5'd0,  5'd18, 0, 0, 1);
    add("dn21", 0, 1, 0, 5'd0,  5'd17, 0, 0, 1);
    add("dn21", 0, 1, 0, 5'd0,  5'd16, 0, 0, 1);
    add("dn21", 0, 0, 0, 5'd0,  5'd16, 0, 0, 0);
    // Load 3, one-shot to zero and hold.
    add("shot3", 1, 0, 0, 5'd3, 5'd3, 0, 0, 0);
    add("shot3", 0, 1, 0, 5'd0, 5'd2, 0, 0, 1);
    add("shot3", 0, 1, 0, 5'd0, 5'd1, 0, 0, 1);
    add("shot3", 0, 1, 0, 5'd0, 5'd0, 1, 1, 0);
    add("shot3", 0, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    add("shot3", 0, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    // Load 2 with auto-reload: periodic 1,2 pattern.
    add("ar2", 1, 0, 1, 5'd2, 5'd2, 0, 0, 0);
    add("ar2", 0, 1, 1, 5'd0, 5'd1, 0, 0, 1);
    add("ar2", 0, 1, 1, 5'd0, 5'd2, 0, 1, 1);
    add("ar2", 0, 1, 1, 5'd0, 5'd1, 0, 0, 1);
    add("ar2", 0, 1, 1, 5'd0, 5'd2, 0, 1, 1);
    add("ar2", 0, 1, 1, 5'd0, 5'd1, 0, 0, 1);
    add("ar2", 0, 1, 1, 5'd0, 5'd2, 0, 1, 1);
    // Load beats enable.
    add("ldwin", 1, 0, 0, 5'd10, 5'd10, 0, 0, 0);
    add("ldwin", 0, 1, 0, 5'd0,  5'd9,  0, 0, 1);
    add("ldwin", 0, 1, 0, 5'd0,  5'd8,  0, 0, 1);
    add("ldwin", 1, 1, 0, 5'd10, 5'd10, 0, 0, 0);
    add("ldwin", 0, 1, 0, 5'd0,  5'd9,  0, 0, 1);
    // Load 0 with enable: stays at zero, no wrap, no pulse.
    add("ld0", 1, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    add("ld0", 0, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    add("ld0", 0, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    add("ld0", 0, 1, 0, 5'd0, 5'd0, 1, 0, 0);
    // Reload value 1: count sticks at 1 and pulses every enabled cycle.
    add("ar1", 1, 0, 1, 5'd1, 5'd1, 0, 0, 0);
    add("ar1", 0, 1, 1, 5'd0, 5'd1, 0, 1, 1);
    add("ar1", 0, 1, 1, 5'd0, 5'd1, 0, 1, 1);
    add("ar1", 0, 1, 0, 5'd0, 5'd0, 1, 1, 0);
    add("ar1", 0, 0, 0, 5'd0, 5'd0, 1, 0, 0);

    // Reset state while rst is held.
    #2;
    check_all("reset", 0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].en, vecs[i].ar, vecs[i].d);
      check_all(vecs[i].name, i, vecs[i].c, vecs[i].z, vecs[i].x, vecs[i].b);
    end

    // Async reset mid-run: outputs clear before any clock edge.
    step(1, 0, 0, 5'd7);
    step(0, 1, 0, 5'd0);
    step(0, 1, 0, 5'd0);
    check_all("pre_rst", 0, 5'd5, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1 check_all("async_rst", 0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 5'd0);
    check_all("post_rst", 0, 5'd0, 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 5'd0);
    check_all("post_rst", 1, 5'd0, 1'b1, 1'b0, 1'b0);

    // Async reset while an expired pulse is showing kills the pulse.
    step(1, 0, 1, 5'd1);
    step(0, 1, 1, 5'd0);
    check_all("pulse_rst_pre", 0, 5'd1, 1'b0, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1 check_all("pulse_rst", 0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 1, 5'd0);
    check_all("pulse_rst_post", 0, 5'd0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
